seq_player: RTL and testbench

- Read-side counterpart of the LFSR sequencer.
- The sequencer fills a 32-entry nibble RAM. seq_player reads entries 0..len-1 back out of that RAM, in address order, over its read port.
- Each entry is presented on a valid/ready stream to the display/game logic.
- finish pulses once the last entry has been accepted.

---
 rtl/seq_pkg.sv | 22 ++
 rtl/seq_gap_timer.sv | 41 ++++
 rtl/seq_player.sv | 190 +++++++++++++++++++
 tb/tb_seq_player.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// seq_pkg: constants and types shared by the LFSR sequencer and the
// playback side (seq_player).
//   SEQ_ADDR_W  - nibble RAM address width
//   SEQ_DATA_W  - stored entry width
//   SEQ_DEPTH   - number of RAM entries, also the maximum play length
//   player_state_e - playback FSM state encoding
package seq_pkg;

    localparam int SEQ_ADDR_W = 5;
    localparam int SEQ_DATA_W = 4;
    localparam int SEQ_DEPTH  = 32;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_READ    = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_PRESENT = 3'd3,
        ST_DONE    = 3'd4,
        ST_GAP     = 3'd5
    } player_state_e;

endpackage

// File: rtl/seq_gap_timer.sv
// seq_gap_timer: small down-counter used to time the blank gap between
// played entries.
// Ports:
//   clk      - clock, rising edge
//   rst      - asynchronous active-low reset
//   load     - load load_val into the counter
//   load_val - terminal distance; expired asserts load_val cycles after load
//   expired  - counter has reached zero
module seq_gap_timer #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         expired
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (cnt_q == '0);

endmodule

// File: rtl/seq_player.sv
// seq_player: plays back entries 0..len-1 of the sequencer's nibble RAM on a
// valid/ready stream and pulses finish once the last entry is accepted.
// Optional feature macro: SEQ_PLAYER_GAP_EN inserts GAP_CYCLES blank cycles
// between entries (not after the last one).
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for start; len sampled here
// READ    | rd_en high for one cycle at rd_addr
// CAPTURE | RAM data arrives; latched into out_data at the next edge
// PRESENT | out_valid high, waiting for out_ready
// GAP     | blank cycles between entries (SEQ_PLAYER_GAP_EN only)
// DONE    | one-cycle finish pulse, then back to IDLE
//
// Ports:
//   clk, rst            - clock (rising) and async active-low reset
//   start, len          - begin playback of len entries (0 = empty, clamps to DEPTH)
//   rd_en, rd_addr      - RAM read strobe/address
//   rd_data             - RAM data, valid one cycle after rd_en
//   out_data, out_valid - presented entry
//   out_ready           - consumer accepts
//   busy, finish        - playback in progress / one-cycle done pulse
module seq_player
    import seq_pkg::*;
#(
    parameter int ADDR_W = SEQ_ADDR_W,
    parameter int DATA_W = SEQ_DATA_W,
    parameter int DEPTH  = SEQ_DEPTH
`ifdef SEQ_PLAYER_GAP_EN
    ,
    parameter int GAP_CYCLES = 4
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W:0]   len,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              finish
);

    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    player_state_e     state_q,     state_d;
    logic              rd_en_q,     rd_en_d;
    logic [ADDR_W-1:0] rd_addr_q,   rd_addr_d;
    logic [DATA_W-1:0] out_data_q,  out_data_d;
    logic              out_valid_q, out_valid_d;
    logic              busy_q,      busy_d;
    logic              finish_q,    finish_d;
    logic [ADDR_W:0]   remaining_q, remaining_d;

`ifdef SEQ_PLAYER_GAP_EN
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    // Loaded on the transfer edge; GAP then lasts GAP_CYCLES cycles.
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    logic gap_load;
    logic gap_expired;

    seq_gap_timer #(
        .W (GAP_W)
    ) u_gap_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (gap_load),
        .load_val (GAP_LOAD),
        .expired  (gap_expired)
    );
`endif

    always_comb begin
        state_d     = state_q;
        rd_en_d     = rd_en_q;
        rd_addr_d   = rd_addr_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        busy_d      = busy_q;
        finish_d    = 1'b0;
        remaining_d = remaining_q;
`ifdef SEQ_PLAYER_GAP_EN
        gap_load    = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (len != '0) begin
                        state_d     = ST_READ;
                        busy_d      = 1'b1;
                        rd_en_d     = 1'b1;
                        rd_addr_d   = '0;
                        remaining_d = (len > DEPTH_L) ? DEPTH_L : len;
                    end else begin
                        state_d  = ST_DONE;
                        finish_d = 1'b1;
                        busy_d   = 1'b0;
                    end
                end
            end
            ST_READ: begin
                rd_en_d = 1'b0;
                state_d = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                out_data_d  = rd_data;
                out_valid_d = 1'b1;
                state_d     = ST_PRESENT;
            end
            ST_PRESENT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    remaining_d = remaining_q - 1'b1;
                    if (remaining_q == (ADDR_W + 1)'(1)) begin
                        state_d  = ST_DONE;
                        finish_d = 1'b1;
                        busy_d   = 1'b0;
                    end else begin
                        rd_addr_d = rd_addr_q + 1'b1;
`ifdef SEQ_PLAYER_GAP_EN
                        if (GAP_CYCLES > 0) begin
                            state_d  = ST_GAP;
                            gap_load = 1'b1;
                        end else begin
                            state_d = ST_READ;
                            rd_en_d = 1'b1;
                        end
`else
                        state_d = ST_READ;
                        rd_en_d = 1'b1;
`endif
                    end
                end
            end
`ifdef SEQ_PLAYER_GAP_EN
            ST_GAP: begin
                if (gap_expired) begin
                    state_d = ST_READ;
                    rd_en_d = 1'b1;
                end
            end
`endif
            ST_DONE: begin
                rd_addr_d = '0;
                state_d   = ST_IDLE;
            end
            default: begin
                state_d     = ST_IDLE;
                rd_en_d     = 1'b0;
                out_valid_d = 1'b0;
                busy_d      = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            rd_en_q     <= 1'b0;
            rd_addr_q   <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            finish_q    <= 1'b0;
            remaining_q <= '0;
        end else begin
            state_q     <= state_d;
            rd_en_q     <= rd_en_d;
            rd_addr_q   <= rd_addr_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            finish_q    <= finish_d;
            remaining_q <= remaining_d;
        end
    end

    assign rd_en     = rd_en_q;
    assign rd_addr   = rd_addr_q;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign finish    = finish_q;

endmodule

// File: tb/tb_seq_player.sv
// tb_seq_player: scoreboard bench for seq_player. A behavioural RAM feeds the
// read port; each start pushes the expected entry stream, a negedge monitor
// pops on every accepted transfer and checks read addresses, stalls and the
// finish pulse.
module tb_seq_player;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 4;
    localparam int DEPTH  = 32;
`ifdef SEQ_PLAYER_GAP_EN
    localparam int PERIOD = 3 + 4;
`else
    localparam int PERIOD = 3;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              start = 1'b0;
    logic [ADDR_W:0]   len = '0;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data = '0;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic              busy;
    logic              finish;

    seq_player dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .len       (len),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .finish    (finish)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] exp_q [$];
    int                xfer_cyc [$];
    int run_n = 0;
    int exp_addr = 0;
    int xfer_in_run = 0;
    int finish_count = 0;
    int finish_cyc = -1;
    int runs = 0;
    int start_cyc = 0;
    int ready_mode = 0;   // 0: always ready, 1: random, 2: driven by the test
    logic prev_finish = 1'b0;
    logic prev_stall = 1'b0;
    logic [DATA_W-1:0] prev_data = '0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural RAM: one-cycle read latency, junk when not read.
    always @(posedge clk) begin
        if (rd_en) rd_data <= mem[rd_addr];
        else       rd_data <= DATA_W'($urandom);
    end

    always @(posedge clk) begin
        #1;
        if (ready_mode == 0)      out_ready = 1'b1;
        else if (ready_mode == 1) out_ready = ($urandom_range(0, 3) != 0);
    end

    always @(negedge clk) begin
        if (!rst) begin
            prev_stall  = 1'b0;
            prev_finish = 1'b0;
        end else begin
            if (rd_en) begin
                chk("rd_en_busy", busy, 1);
                chk("rd_en_no_valid", out_valid, 0);
                chk("rd_addr", rd_addr, exp_addr);
                exp_addr++;
                chk("rd_count_limit", exp_addr <= run_n, 1);
            end
            if (prev_stall) begin
                chk("stall_valid", out_valid, 1);
                chk("stall_data", out_data, prev_data);
            end
            if (out_valid && out_ready) begin
                chk("sb_nonempty", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) chk("entry", out_data, exp_q.pop_front());
                xfer_cyc.push_back(cyc + 1);
                xfer_in_run++;
            end
            if (finish) begin
                chk("finish_busy", busy, 0);
                chk("finish_consec", prev_finish, 0);
                chk("finish_all_delivered", exp_q.size(), 0);
                chk("finish_rd_count", exp_addr, run_n);
                finish_count++;
                finish_cyc = cyc;
            end
            prev_finish = finish;
            prev_stall  = out_valid && !out_ready;
            prev_data   = out_data;
        end
    end

    // Expected behaviour of one run: entries 0..min(n,DEPTH)-1 in order.
    task automatic start_play(input int n);
        int eff;
        @(posedge clk);
        #1;
        eff = (n > DEPTH) ? DEPTH : n;
        for (int i = 0; i < eff; i++) exp_q.push_back(mem[i]);
        run_n = eff;
        exp_addr = 0;
        xfer_in_run = 0;
        xfer_cyc.delete();
        start = 1'b1;
        len = (ADDR_W + 1)'(n);
        runs++;
        @(posedge clk);
        #1;
        start_cyc = cyc;
        start = 1'b0;
        len = (ADDR_W + 1)'($urandom);
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget && finish_count < runs; i++) @(posedge clk);
        chk("done_timeout", finish_count, runs);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int fc;
        for (int i = 0; i < DEPTH; i++) mem[i] = DATA_W'(i % 16);
        #1;
        chk("reset_rd_en", rd_en, 0);
        chk("reset_rd_addr", rd_addr, 0);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_out_data", out_data, 0);
        chk("reset_busy", busy, 0);
        chk("reset_finish", finish, 0);
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;

        // len=5, ready held high: latency and throughput
        ready_mode = 0;
        start_play(5);
        chk("e0_busy", busy, 1);
        chk("e0_rd_en", rd_en, 1);
        chk("e0_rd_addr", rd_addr, 0);
        chk("e0_out_valid", out_valid, 0);
        @(posedge clk); #1;
        chk("e1_rd_en", rd_en, 0);
        chk("e1_out_valid", out_valid, 0);
        @(posedge clk); #1;
        chk("e2_out_valid", out_valid, 1);
        chk("e2_out_data", out_data, mem[0]);
        wait_done(200);
        chk("len5_xfers", xfer_cyc.size(), 5);
        if (xfer_cyc.size() == 5) begin
            chk("first_xfer_edge", xfer_cyc[0] - start_cyc, 3);
            for (int i = 1; i < 5; i++) chk("xfer_period", xfer_cyc[i] - xfer_cyc[i-1], PERIOD);
            chk("finish_after_last", finish_cyc, xfer_cyc[4]);
        end

        // Backpressure on entry 1
        ready_mode = 2;
        out_ready = 1'b1;
        start_play(3);
        for (int i = 0; i < 100 && xfer_in_run < 1; i++) begin @(posedge clk); #1; end
        out_ready = 1'b0;
        for (int i = 0; i < 100 && !out_valid; i++) begin @(posedge clk); #1; end
        chk("stall_entry1", out_data, mem[1]);
        repeat (7) @(posedge clk);
        #1;
        chk("stall_end_valid", out_valid, 1);
        out_ready = 1'b1;
        wait_done(200);
        chk("bp_xfers", xfer_in_run, 3);

        // Empty playback
        ready_mode = 0;
        start_play(0);
        wait_done(50);
        chk("len0_finish_edge", finish_cyc, start_cyc);
        chk("len0_xfers", xfer_in_run, 0);

        // Length clamp
        for (int i = 0; i < DEPTH; i++) mem[i] = DATA_W'($urandom);
        start_play(40);
        wait_done(1000);
        chk("clamp_xfers", xfer_in_run, DEPTH);
        chk("clamp_reads", exp_addr, DEPTH);

        // Reset during PRESENT of entry 2
        ready_mode = 2;
        out_ready = 1'b1;
        start_play(6);
        for (int i = 0; i < 100 && xfer_in_run < 2; i++) begin @(posedge clk); #1; end
        out_ready = 1'b0;
        for (int i = 0; i < 100 && !out_valid; i++) begin @(posedge clk); #1; end
        chk("pre_reset_entry2", out_data, mem[2]);
        fc = finish_count;
        #2 rst = 1'b0;
        #1;
        chk("arst_rd_en", rd_en, 0);
        chk("arst_rd_addr", rd_addr, 0);
        chk("arst_out_valid", out_valid, 0);
        chk("arst_out_data", out_data, 0);
        chk("arst_busy", busy, 0);
        chk("arst_finish", finish, 0);
        exp_q.delete();
        runs--;
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("no_finish_after_abort", finish_count, fc);
        ready_mode = 0;
        start_play(3);
        wait_done(200);
        chk("replay_xfers", xfer_in_run, 3);

        // Randomized runs with random backpressure
        ready_mode = 1;
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < DEPTH; i++) mem[i] = DATA_W'($urandom);
            start_play((r == 2) ? 0 : (r == 5) ? 63 : $urandom_range(1, 40));
            wait_done(3000);
        end

        ready_mode = 0;
        repeat (5) @(posedge clk);
        #1;
        chk("final_finish_total", finish_count, runs);
        chk("final_busy", busy, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
